// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the RV32 decode stage: opcodes, control-field
// encodings and the control bundle carried from D into EX.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } src_a_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        src_a_e      alu_src_a;
        logic        alu_src_b;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        logic [1:0]  alu_op;
        logic        jump;
        logic        jump_r;
        logic        mul_div;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_table.sv
// Combinational opcode/funct7 decoder producing the control bundle and an
// illegal-instruction flag; illegal encodings yield an all-zero bundle.
module ctrl_table
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic                      valid,
    input  logic [6:0]                opcode,
    input  logic [6:0]                funct7,
    output logic [$bits(ctrl_t)-1:0]  ctrl,
    output logic                      illegal
);

    ctrl_t dec;
    logic  known;

    always_comb begin
        dec   = CTRL_NOP;
        known = 1'b1;
        case (opcode)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec.imm_src   = IMM_S;
                dec.alu_src_b = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                if (funct7 == F7_MULDIV) begin
                    dec.mul_div = ENABLE_M;
                    known       = ENABLE_M;
                end
            end
            OP_BRANCH: begin
                dec.imm_src = IMM_B;
                dec.branch  = 1'b1;
                dec.alu_op  = 2'b01;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = IMM_J;
                dec.result_src = RES_PC4;
                dec.alu_op     = 2'b01;
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.result_src = RES_PC4;
                dec.alu_op     = 2'b10;
                dec.jump_r     = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_src_a = SRCA_ZERO;
                dec.alu_src_b = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_U;
                dec.alu_src_a = SRCA_PC;
                dec.alu_src_b = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign illegal = valid && !known;
    assign ctrl    = illegal ? CTRL_NOP : dec;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Decode control unit with ID/EX control register; back-pressures decode while
// a multi-cycle DIV/REM occupies EX.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter bit          ENABLE_M    = 1'b1,
    parameter int unsigned DIV_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ValidD,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       StallE,
    input  logic       FlushE,
    output logic       StallD,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       JumpE,
    output logic       JumpRE,
    output logic       BranchE,
    output logic       ALUSrcBE,
    output logic [1:0] ALUSrcAE,
    output logic [1:0] ResultSrcE,
    output logic [2:0] ImmSrcE,
    output logic [1:0] ALUopE,
    output logic [2:0] Funct3E,
    output logic       MulDivE,
    output logic       ValidE,
    output logic       IllegalE
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LATENCY - 1);

    logic [$bits(ctrl_t)-1:0] dec_bits;
    ctrl_t                    dec;
    ctrl_t                    ctrl_e;
    logic                     illegal;
    logic                     valid_e;
    logic                     illegal_e;
    logic [2:0]               funct3_e;
    logic                     load;
    logic                     div_start;
    state_e                   state, state_next;
    logic [3:0]               cnt, cnt_next;

    ctrl_table #(
        .ENABLE_M (ENABLE_M)
    ) u_table (
        .valid   (ValidD),
        .opcode  (opcode),
        .funct7  (funct7),
        .ctrl    (dec_bits),
        .illegal (illegal)
    );

    assign dec       = ctrl_t'(dec_bits);
    assign StallD    = (state == BUSY);
    assign load      = !(StallE || StallD);
    assign div_start = load && ValidD && dec.mul_div && funct3[2];

    // FlushE overrides the countdown so an aborted divide releases decode next cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (div_start) begin
                    state_next = BUSY;
                    cnt_next   = DIV_CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (FlushE) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || FlushE) begin
            ctrl_e    <= CTRL_NOP;
            valid_e   <= 1'b0;
            illegal_e <= 1'b0;
            funct3_e  <= '0;
        end else if (load) begin
            ctrl_e    <= ValidD ? dec : CTRL_NOP;
            valid_e   <= ValidD;
            illegal_e <= illegal;
            funct3_e  <= (ValidD && !illegal) ? funct3 : 3'b000;
        end
    end

    assign RegWriteE  = ctrl_e.reg_write;
    assign MemWriteE  = ctrl_e.mem_write;
    assign JumpE      = ctrl_e.jump;
    assign JumpRE     = ctrl_e.jump_r;
    assign BranchE    = ctrl_e.branch;
    assign ALUSrcBE   = ctrl_e.alu_src_b;
    assign ALUSrcAE   = ctrl_e.alu_src_a;
    assign ResultSrcE = ctrl_e.result_src;
    assign ImmSrcE    = ctrl_e.imm_src;
    assign ALUopE     = ctrl_e.alu_op;
    assign Funct3E    = funct3_e;
    assign MulDivE    = ctrl_e.mul_div;
    assign ValidE     = valid_e;
    assign IllegalE   = illegal_e;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed scoreboard bench for ctrl_decode_pipe: decode table, illegal
// handling, DIV/REM back-pressure, flush/stall priority and mid-divide reset.
module tb_ctrl_decode_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ValidD, StallE, FlushE;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    logic       StallD, RegWriteE, MemWriteE, JumpE, JumpRE, BranchE, ALUSrcBE;
    logic [1:0] ALUSrcAE, ResultSrcE, ALUopE;
    logic [2:0] ImmSrcE, Funct3E;
    logic       MulDivE, ValidE, IllegalE;

    logic       valid2;
    logic [6:0] opcode2, funct7_2;
    logic [2:0] funct3_2;
    logic       n_StallD, n_RegWriteE, n_MemWriteE, n_JumpE, n_JumpRE, n_BranchE, n_ALUSrcBE;
    logic [1:0] n_ALUSrcAE, n_ResultSrcE, n_ALUopE;
    logic [2:0] n_ImmSrcE, n_Funct3E;
    logic       n_MulDivE, n_ValidE, n_IllegalE;

    ctrl_decode_pipe #(.ENABLE_M(1'b1), .DIV_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .StallE(StallE), .FlushE(FlushE), .StallD(StallD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JumpRE(JumpRE),
        .BranchE(BranchE), .ALUSrcBE(ALUSrcBE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
        .ImmSrcE(ImmSrcE), .ALUopE(ALUopE), .Funct3E(Funct3E), .MulDivE(MulDivE),
        .ValidE(ValidE), .IllegalE(IllegalE)
    );

    ctrl_decode_pipe #(.ENABLE_M(1'b0), .DIV_LATENCY(4)) dut_nom (
        .clk(clk), .rst_n(rst_n), .ValidD(valid2), .opcode(opcode2), .funct3(funct3_2),
        .funct7(funct7_2), .StallE(1'b0), .FlushE(1'b0), .StallD(n_StallD),
        .RegWriteE(n_RegWriteE), .MemWriteE(n_MemWriteE), .JumpE(n_JumpE), .JumpRE(n_JumpRE),
        .BranchE(n_BranchE), .ALUSrcBE(n_ALUSrcBE), .ALUSrcAE(n_ALUSrcAE),
        .ResultSrcE(n_ResultSrcE), .ImmSrcE(n_ImmSrcE), .ALUopE(n_ALUopE),
        .Funct3E(n_Funct3E), .MulDivE(n_MulDivE), .ValidE(n_ValidE), .IllegalE(n_IllegalE)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [20:0] exp_q[$];
    string       tag_q[$];

    // Expected E image: {valid, illegal, muldiv, jumpr, funct3, 14-bit bundle}.
    function automatic logic [20:0] model(input logic v, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic en_m);
        logic [13:0] b;
        logic jr, md, ill;
        jr = 1'b0; md = 1'b0; ill = 1'b0; b = '0;
        case (op)
            7'b0000011: b = 14'b1_000_00_1_0_01_0_00_0;
            7'b0100011: b = 14'b0_001_00_1_1_00_0_00_0;
            7'b0110011: begin
                b = 14'b1_000_00_0_0_00_0_10_0;
                if (f7 == 7'b0000001) begin
                    if (en_m) md = 1'b1;
                    else      ill = 1'b1;
                end
            end
            7'b1100011: b = 14'b0_010_00_0_0_00_1_01_0;
            7'b0010011: b = 14'b1_000_00_1_0_00_0_10_0;
            7'b1101111: b = 14'b1_011_00_0_0_10_0_01_1;
            7'b1100111: begin b = 14'b1_000_00_1_0_10_0_10_0; jr = 1'b1; end
            7'b0110111: b = 14'b1_100_10_1_0_00_0_00_0;
            7'b0010111: b = 14'b1_100_01_1_0_00_0_00_0;
            default:    ill = 1'b1;
        endcase
        if (!v)  return '0;
        if (ill) return {2'b11, 19'b0};
        return {1'b1, 1'b0, md, jr, f3, b};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {ValidE, IllegalE, MulDivE, JumpRE, Funct3E, RegWriteE, ImmSrcE, ALUSrcAE,
                ALUSrcBE, MemWriteE, ResultSrcE, BranchE, ALUopE, JumpE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_e(input string tag, input logic [20:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_e();
        string       tag;
        logic [20:0] exp;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 21'd1, 21'd0);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            chk(tag, dut_vec(), exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        ValidD = v; opcode = op; funct3 = f3; funct7 = f7;
    endtask

    logic [6:0]  ops [9];
    logic [20:0] div_v;

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        valid2 = 1'b0; opcode2 = '0; funct3_2 = '0; funct7_2 = '0;

        expect_e("reset_e", '0);
        tick(); tick();
        check_e();
        chk("reset_stalld", 21'(StallD), 21'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i], 3'(i), 7'b0);
            expect_e($sformatf("table_%0d", i), model(1'b1, ops[i], 3'(i), 7'b0, 1'b1));
            tick();
            check_e();
            if (ops[i] == 7'b1100111) chk("jalr_jumpre", 21'(JumpRE), 21'd1);
        end

        drive(1'b1, 7'b1111111, 3'b000, 7'b0);
        expect_e("illegal_op", model(1'b1, 7'b1111111, 3'b000, 7'b0, 1'b1));
        tick();
        check_e();

        drive(1'b0, 7'b0000011, 3'b010, 7'b0);
        expect_e("invalid_d", '0);
        tick();
        check_e();

        drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
        div_v = model(1'b1, 7'b0110011, 3'b100, 7'b0000001, 1'b1);
        expect_e("div_load", div_v);
        tick();
        check_e();
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        StallE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk($sformatf("div_stalld_%0d", i), 21'(StallD), 21'(i < 4));
            expect_e($sformatf("div_hold_%0d", i), div_v);
            check_e();
            if (i == 3) StallE = 1'b0;
        end
        expect_e("after_div_lw", model(1'b1, 7'b0000011, 3'b010, 7'b0, 1'b1));
        tick();
        check_e();

        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001);
        expect_e("mul_load", model(1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b1));
        tick();
        check_e();
        chk("mul_stalld_0", 21'(StallD), 21'd0);
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        expect_e("after_mul_lw", model(1'b1, 7'b0000011, 3'b010, 7'b0, 1'b1));
        tick();
        check_e();
        chk("mul_stalld_1", 21'(StallD), 21'd0);

        StallE = 1'b1; FlushE = 1'b1;
        expect_e("flush_beats_stall", '0);
        tick();
        check_e();
        StallE = 1'b0; FlushE = 1'b0;

        drive(1'b1, 7'b0110011, 3'b110, 7'b0000001);
        expect_e("rem_load", model(1'b1, 7'b0110011, 3'b110, 7'b0000001, 1'b1));
        tick();
        check_e();
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        tick();
        chk("rem_busy2_stalld", 21'(StallD), 21'd1);
        FlushE = 1'b1;
        expect_e("busy_flush_e", '0);
        tick();
        check_e();
        chk("busy_flush_stalld", 21'(StallD), 21'd0);
        FlushE = 1'b0;
        expect_e("after_flush_lw", model(1'b1, 7'b0000011, 3'b010, 7'b0, 1'b1));
        tick();
        check_e();

        drive(1'b1, 7'b0110011, 3'b101, 7'b0000001);
        expect_e("divu_load", model(1'b1, 7'b0110011, 3'b101, 7'b0000001, 1'b1));
        tick();
        check_e();
        drive(1'b1, 7'b0000011, 3'b010, 7'b0);
        tick();
        chk("divu_busy_stalld", 21'(StallD), 21'd1);
        rst_n = 1'b0;
        expect_e("midbusy_reset_e", '0);
        tick();
        check_e();
        chk("midbusy_reset_stalld", 21'(StallD), 21'd0);
        rst_n = 1'b1;
        expect_e("after_reset_lw", model(1'b1, 7'b0000011, 3'b010, 7'b0, 1'b1));
        tick();
        check_e();

        valid2 = 1'b1; opcode2 = 7'b0110011; funct3_2 = 3'b100; funct7_2 = 7'b0000001;
        tick();
        chk("nom_div_illegal", 21'({n_ValidE, n_IllegalE, n_MulDivE, n_RegWriteE, n_MemWriteE}),
            21'(5'b11000));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nom_stalld_%0d", i), 21'(n_StallD), 21'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
